// File: rtl/regfile.sv
// 32 x WIDTH register file: two combinational read ports, one write port and a
// priority status port into STATUS_REG; register 0 is constant zero.
module regfile #(
  parameter int WIDTH      = 32,
  parameter int REGS       = 32,
  parameter int STATUS_REG = 30,
  parameter bit BYPASS     = 1'b1,
  localparam int IDX_W     = $clog2(REGS)
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_writeEnable,
  input  logic [IDX_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic             ctrl_statusWrite,
  input  logic [WIDTH-1:0] data_status,
  input  logic [IDX_W-1:0] ctrl_readRegA,
  input  logic [IDX_W-1:0] ctrl_readRegB,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB
);

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] rd_view [REGS];
  logic             hit_a;
  logic             hit_b;

  // An overflowing result must never commit, so the status write replaces
  // the normal write outright rather than merely winning on a shared index.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_data = '0;
    if (ctrl_statusWrite) begin
      wr_en   = 1'b1;
      wr_idx  = IDX_W'(STATUS_REG);
      wr_data = data_status;
    end else if (ctrl_writeEnable && (ctrl_writeReg != '0)) begin
      wr_en   = 1'b1;
      wr_idx  = ctrl_writeReg;
      wr_data = data_writeReg;
    end
  end

  assign rd_view[0] = '0;

  for (genvar gi = 1; gi < REGS; gi++) begin : g_reg
    logic [WIDTH-1:0] reg_q;

    always_ff @(posedge clock) begin
      if (ctrl_reset) begin
        reg_q <= '0;
      end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
        reg_q <= wr_data;
      end
    end

    assign rd_view[gi] = reg_q;
  end

  // wr_en already excludes index 0, so a hit implies a nonzero read index.
  assign hit_a = BYPASS && !ctrl_reset && wr_en && (ctrl_readRegA == wr_idx);
  assign hit_b = BYPASS && !ctrl_reset && wr_en && (ctrl_readRegB == wr_idx);

  assign data_readRegA = hit_a ? wr_data : rd_view[ctrl_readRegA];
  assign data_readRegB = hit_b ? wr_data : rd_view[ctrl_readRegB];

endmodule
